// File: rtl/nibble_code_lock.sv
// Sequential code lock: per-digit nibble compare, failed-attempt accounting and timed lockout.
// Optional timed auto-relock from OPEN is built when NIBBLE_LOCK_AUTORELOCK_EN is defined.
//
// state   | meaning
// ENTRY   | collecting DIGITS digits of an attempt
// OPEN    | code accepted; code_load/relock honoured
// LOCKOUT | MAX_FAIL failures reached; inputs ignored until counter expires
module nibble_code_lock #(
  parameter int DIGITS         = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  relock,
  input  logic                  code_load,
  input  logic [4*DIGITS-1:0]   code_in,
  output logic                  unlocked,
  output logic                  fail,
  output logic                  locked_out,
  output logic [2:0]            digit_idx,
  output logic [3:0]            fail_cnt
);

  if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || MAX_FAIL > 15 ||
      LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535 ||
      OPEN_CYCLES < 1 || OPEN_CYCLES > 65535) begin : g_param_check
    $error("nibble_code_lock: parameter out of range");
  end

  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} state_t;

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] code, code_nxt;
  logic [2:0]          idx_nxt;
  logic [3:0]          fail_cnt_nxt;
  logic                mismatch, mismatch_nxt;
  logic [15:0]         lock_cnt, lock_cnt_nxt;
  logic                fail_nxt;
  logic [3:0]          exp_digit;
  logic                attempt_bad;
`ifdef NIBBLE_LOCK_AUTORELOCK_EN
  logic [15:0]         open_cnt, open_cnt_nxt;
`endif

  always_comb begin
    exp_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == 3'(k)) exp_digit = code[4*k +: 4];
    end
    // the sticky flag is ignored on digit 0 so every attempt starts clean
    attempt_bad = ((digit_idx != 3'd0) && mismatch) || (digit != exp_digit);
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    idx_nxt      = digit_idx;
    fail_cnt_nxt = fail_cnt;
    mismatch_nxt = mismatch;
    lock_cnt_nxt = lock_cnt;
    fail_nxt     = 1'b0;
`ifdef NIBBLE_LOCK_AUTORELOCK_EN
    open_cnt_nxt = open_cnt;
`endif
    case (state)
      ENTRY: begin
        if (digit_valid) begin
          if (digit_idx == LAST_IDX) begin
            idx_nxt      = 3'd0;
            mismatch_nxt = 1'b0;
            if (!attempt_bad) begin
              state_nxt    = OPEN;
              fail_cnt_nxt = 4'd0;
`ifdef NIBBLE_LOCK_AUTORELOCK_EN
              open_cnt_nxt = 16'(OPEN_CYCLES);
`endif
            end else begin
              fail_nxt     = 1'b1;
              fail_cnt_nxt = fail_cnt + 4'd1;
              if (fail_cnt_nxt == 4'(MAX_FAIL)) begin
                state_nxt    = LOCKOUT;
                lock_cnt_nxt = 16'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            idx_nxt      = digit_idx + 3'd1;
            mismatch_nxt = attempt_bad;
          end
        end
      end
      OPEN: begin
        if (code_load) code_nxt = code_in;
`ifdef NIBBLE_LOCK_AUTORELOCK_EN
        open_cnt_nxt = open_cnt - 16'd1;
        if (relock || open_cnt <= 16'd1) begin
          state_nxt    = ENTRY;
          open_cnt_nxt = 16'd0;
        end
`else
        if (relock) state_nxt = ENTRY;
`endif
      end
      LOCKOUT: begin
        lock_cnt_nxt = lock_cnt - 16'd1;
        // terminal count: leave on the same edge the counter reaches zero
        if (lock_cnt <= 16'd1) begin
          state_nxt    = ENTRY;
          lock_cnt_nxt = 16'd0;
          fail_cnt_nxt = 4'd0;
          idx_nxt      = 3'd0;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTRY;
      code       <= '0;
      digit_idx  <= 3'd0;
      fail_cnt   <= 4'd0;
      mismatch   <= 1'b0;
      lock_cnt   <= 16'd0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      digit_idx  <= idx_nxt;
      fail_cnt   <= fail_cnt_nxt;
      mismatch   <= mismatch_nxt;
      lock_cnt   <= lock_cnt_nxt;
      unlocked   <= (state_nxt == OPEN);
      fail       <= fail_nxt;
      locked_out <= (state_nxt == LOCKOUT);
    end
  end

`ifdef NIBBLE_LOCK_AUTORELOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) open_cnt <= 16'd0;
    else        open_cnt <= open_cnt_nxt;
  end
`endif

endmodule
